// File: rtl/dmem_wait_responder.sv
// Data-memory slave for the core's D-port: accepts one request, waits WAIT_CYCLES,
// then answers with a one-cycle RDY (plus ERR for out-of-range accesses).
//
// state | meaning
// IDLE  | waiting for CSN=0; request captured on the accepting edge
// WAIT  | counting wait states, inputs ignored
// RESP  | RDY high for one cycle; write commits on the edge leaving RESP
module dmem_wait_responder #(
    parameter int AWIDTH      = 12,
    parameter int WAIT_CYCLES = 2,
    parameter int DWIDTH      = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              CSN,
    input  logic              WEN,
    input  logic [3:0]        BE,
    input  logic [31:0]       ADDR,
    input  logic [DWIDTH-1:0] DI,
    output logic [DWIDTH-1:0] DOUT,
    output logic              RDY,
    output logic              ERR,
    output logic              BUSY
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state_q, state_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic                wen_q, wen_d;
    logic [3:0]          be_q, be_d;
    logic [AWIDTH-1:0]   idx_q, idx_d;
    logic [DWIDTH-1:0]   di_q, di_d;
    logic                oor_q, oor_d;

    logic [DWIDTH-1:0]   mem [2**AWIDTH];
    logic                mem_we;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^ADDR[1:0];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            wen_q      <= 1'b1;
            be_q       <= 4'd0;
            idx_q      <= '0;
            di_q       <= '0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wen_q      <= wen_d;
            be_q       <= be_d;
            idx_q      <= idx_d;
            di_q       <= di_d;
            oor_q      <= oor_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wen_d      = wen_q;
        be_d       = be_q;
        idx_d      = idx_q;
        di_d       = di_q;
        oor_d      = oor_q;
        case (state_q)
            IDLE: begin
                if (!CSN) begin
                    wen_d = WEN;
                    be_d  = BE;
                    idx_d = ADDR[AWIDTH+1:2];
                    di_d  = DI;
                    oor_d = |ADDR[31:AWIDTH+2];
                    if (WAIT_CYCLES > 0) begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset forces state_q to IDLE asynchronously, so an aborted write never reaches mem_we.
    assign mem_we = (state_q == RESP) && !wen_q && !oor_q;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx_q][8*i +: 8] <= di_q[8*i +: 8];
            end
        end
    end

    assign RDY  = (state_q == RESP);
    assign ERR  = RDY && oor_q;
    assign BUSY = (state_q != IDLE);
    assign DOUT = (RDY && wen_q && !oor_q) ? mem[idx_q] : '0;

endmodule

// File: doc/dmem_wait_responder.md
Name: dmem_wait_responder

Overview:
- Data-memory responder: the memory end of the core's D-memory port (CSN/WEN/BE/ADDR/DI/DOUT).
- Replaces the zero-wait SRAM model with a slave that inserts a programmable number of wait states and signals completion with a ready pulse.
- Lets the core's stall/hold logic be exercised against slow memory.
- Owns its storage array and flags out-of-range accesses.

Parameters:
- AWIDTH, 12, word-address width; storage depth is 2^AWIDTH words.
- WAIT_CYCLES, 2, wait states inserted between request accept and response (0..15).
- DWIDTH, 32, data word width; fixed at 32 with 4 byte lanes.

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RSTn  in  1  asynchronous active-low reset
- CSN  in  1  chip select, active-low; low = request present
- WEN  in  1  write enable, active-low; 0 = write, 1 = read
- BE  in  4  byte enables, active-high; BE[i] selects DI[8i+7:8i]; used for writes only
- ADDR  in  32  byte address; word index = ADDR[AWIDTH+1:2]; ADDR[1:0] ignored
- DI  in  32  write data
- DOUT  out  32  read data; valid only while RDY=1
- RDY  out  1  one-cycle completion pulse
- ERR  out  1  asserted together with RDY when the access was out of range
- BUSY  out  1  high from request accept until RDY cycle inclusive

Behaviour:
- Reset (RSTn low, asynchronous): state=IDLE, DOUT=0, RDY=0, ERR=0, BUSY=0, wait counter=0. Storage array is not cleared.
- Reset asserted mid-transaction aborts it. A pending write is not committed. No RDY is produced.
- States:
  - IDLE: accept when CSN=0. On accept, capture WEN/BE/ADDR/DI into request registers. Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - WAIT: count WAIT_CYCLES cycles, then go to RESP.
  - RESP: one cycle, then return to IDLE.
- Inputs are ignored outside IDLE. The request registers alone define the transaction. The core holds CSN low until it sees RDY.
- Latency: RDY rises WAIT_CYCLES+1 cycles after the accepting edge. WAIT_CYCLES=0 gives RDY the cycle after accept.
- Throughput: one access per WAIT_CYCLES+2 cycles. A new accept is possible in the IDLE cycle following RESP.
- Back-to-back requests: if CSN is still low in the IDLE cycle after RESP, that cycle is a new accept.
- Read: DOUT = mem[word index] in the RESP cycle. DOUT returns to 0 when RDY drops.
- Write: in the RESP cycle, bytes with BE[i]=1 are updated and other bytes are kept. DOUT=0. BE=0000 still completes with RDY and changes nothing.
- Read-after-write to the same word in consecutive transactions returns the merged new value.
- Range check: ADDR[31:AWIDTH+2] != 0 means out of range. Such an access still completes with RDY. ERR=1 in the RESP cycle, no write occurs, and DOUT=0.
- Wait counter: 4-bit. It loads WAIT_CYCLES-1 on entering WAIT and leaves WAIT at 0.

Test Plan:
- Reset/idle: hold RSTn=0 for 3 cycles, release with CSN=1 -> DOUT=0, RDY=0, ERR=0, BUSY=0 for 10 cycles.
- Write then read (WAIT_CYCLES=2):
  - Write ADDR=0x10, DI=0xDEADBEEF, BE=1111 -> RDY exactly 3 cycles after accept, BUSY high 3 cycles.
  - Read ADDR=0x10 -> DOUT=0xDEADBEEF with RDY.
- Byte-lane merge: after the above, write ADDR=0x10, DI=0x00001122, BE=0011 -> read returns 0xDEAD1122. Write with BE=0000 -> word unchanged, RDY still pulses.
- Out of range (AWIDTH=12): write ADDR=0x4000 -> RDY=1 and ERR=1 in the same cycle. Word 0 is unchanged on readback. Read ADDR=0x4004 -> DOUT=0, ERR=1.
- Zero-wait and back-to-back (WAIT_CYCLES=0): CSN held low over 3 reads of 0x0/0x4/0x8 -> RDY at cycles 1, 3, 5 after the first accept, each with the correct data.
- Reset mid-write: accept write DI=0x12345678 to ADDR=0x20, assert RSTn low during WAIT -> no RDY. Readback of 0x20 after reset returns its pre-write value.
